regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback stage plus register file for the 8-bit CPU datapath, sitting at the far end of the execute stage's write interface. It captures the destination address and result produced by the execute stage, commits them to a 16 x 8-bit register file one cycle later, and serves two registered read ports that feed source operands back to the execute stage. Optional forwarding returns in-flight results to readers without waiting for the commit.

## Interface
Parameters:
- DATA_W, 8, register and data width
- ADDR_W, 4, register address width
- NUM_REGS, 16, register count (2**ADDR_W)

Ports:
- i_clk  input  1  single clock, rising-edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_wr_valid  input  1  execute result valid this cycle
- i_write_add  input  ADDR_W  destination register from execute
- i_write_data  input  DATA_W  result from execute
- i_rd_en  input  1  read request for both ports
- i_rd_add_1  input  ADDR_W  source register 1
- i_rd_add_2  input  ADDR_W  source register 2
- o_srcdata_1  output  DATA_W  operand 1 to execute
- o_srcdata_2  output  DATA_W  operand 2 to execute
- o_rd_valid  output  1  operands updated this cycle
- o_commit_cnt  output  8  count of committed writes

Clocking: one clock; reset is asynchronous and active-low.

## Operation
- Writeback pipeline register holds wb_valid, wb_add and wb_data.
  - Loaded every edge from i_wr_valid, i_write_add and i_write_data.
  - wb_valid is cleared when i_wr_valid is low.
- Commit: when wb_valid=1 and wb_add!=0, the edge writes wb_data into reg[wb_add] and increments o_commit_cnt.
- R0 is hardwired to zero.
  - Writes to R0 are dropped.
  - A write to R0 does not increment o_commit_cnt.
  - Reads of R0 return 0 regardless of any bypass.
- Read: on an edge with i_rd_en=1, both o_srcdata_x register the selected source and o_rd_valid=1 for one cycle.
  - With i_rd_en=0, o_srcdata_x hold their last value and o_rd_valid=0.
- Read source priority with bypass compiled in:
  1. Incoming i_write_data, if i_wr_valid and the addresses match.
  2. wb_data, if wb_valid and the addresses match.
  3. The array.
- Both read ports may address the same register. Each port resolves independently.
- o_commit_cnt wraps from 255 to 0.

## Timing
- Reset values: all registers 0; wb_valid 0; o_srcdata_1/2 0; o_rd_valid 0; o_commit_cnt 0.
- Reset is asynchronous and takes effect immediately.
  - A pending writeback is discarded.
  - Reset mid-operation loses any uncommitted result.
- Write latency: execute result presented at edge N is captured at edge N and committed at edge N+1.
  - Array reads see the new value from edge N+2.
- Read latency: one cycle from i_rd_en sample to o_srcdata valid.
- Simultaneous commit and read of the same register at edge M:
  - Bypass on: the read returns the new value.
  - Bypass off: the read returns the pre-commit value, because the array is read before the write.
- Back-to-back writes to the same register commit in order; the last one wins.

## Configuration
- REGFILE_BYPASS_EN defined: read paths use the three-level priority mux. A dependent instruction may issue in the cycle immediately after its producer.
- REGFILE_BYPASS_EN undefined: reads come from the array only. The issue logic must insert two bubbles between a producer and its dependent, and the mux logic is absent.

## Structure
- Shared package cpu_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS
  - REG_ZERO = 4'd0
  - the reg_addr_t and data_t typedefs, shared with the execute stage and ALU.
- Sub-module reg_array: NUM_REGS x DATA_W storage with one synchronous write port, two combinational read ports, and an R0 read forced to 0.
- The writeback register, bypass muxes, output registers and counter live in the top.

## Test plan
- Reset, then i_rd_en with adds 3/7 -> o_srcdata 0/0, o_rd_valid=1 after one cycle, o_commit_cnt=0.
- Write R5=0xA5 with no bypass, read R5 at N+2 -> 0xA5; read at N+1 -> 0x00.
- With REGFILE_BYPASS_EN, write R2=0x3C and read R2 in the same cycle -> 0x3C. Read at N+1 also -> 0x3C.
- Write R0=0xFF, then read R0 -> 0x00, and o_commit_cnt is unchanged.
- 256 committed writes to R1 -> o_commit_cnt wraps to 0.
- Assert i_rst_n low after a write is captured but before commit -> register still 0 after reset release.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths, register-zero address and operand typedefs
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;
  localparam reg_addr_t REG_ZERO = 4'd0;
endpackage

// File: rtl/regfile_writeback_reg_array.sv
// reg_array: NUM_REGS x DATA_W storage, one sync write port, two comb read ports, R0 reads as zero
module reg_array
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  reg_addr_t wa,
  input  data_t     wd,
  input  reg_addr_t ra_1,
  input  reg_addr_t ra_2,
  output data_t     rd_1,
  output data_t     rd_2
);
  data_t mem [NUM_REGS];
  // storage: cleared on reset, written on commit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    else if (we)
      mem[wa] <= wd;
  // read ports: R0 is hardwired to zero
  always_comb begin
    rd_1 = ra_1 == REG_ZERO ? '0 : mem[ra_1];
    rd_2 = ra_2 == REG_ZERO ? '0 : mem[ra_2];
  end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: writeback register, 16x8 register file, two registered read ports; REGFILE_BYPASS_EN adds forwarding
module regfile_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int NUM_REGS_P = NUM_REGS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_valid,
  input  logic [ADDR_W_P-1:0] i_write_add,
  input  logic [DATA_W_P-1:0] i_write_data,
  input  logic                i_rd_en,
  input  logic [ADDR_W_P-1:0] i_rd_add_1,
  input  logic [ADDR_W_P-1:0] i_rd_add_2,
  output logic [DATA_W_P-1:0] o_srcdata_1,
  output logic [DATA_W_P-1:0] o_srcdata_2,
  output logic                o_rd_valid,
  output logic [7:0]          o_commit_cnt
);
  logic      wb_valid;
  reg_addr_t wb_add;
  data_t     wb_data, arr_1, arr_2, src_1, src_2;
  logic      commit;
  assign commit = wb_valid && wb_add != REG_ZERO;
  // writeback pipeline register, reloaded every edge
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wb_valid <= 1'b0;
      wb_add   <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= i_wr_valid;
      wb_add   <= i_write_add;
      wb_data  <= i_write_data;
    end
  reg_array u_array (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .we   (commit),
    .wa   (wb_add),
    .wd   (wb_data),
    .ra_1 (i_rd_add_1),
    .ra_2 (i_rd_add_2),
    .rd_1 (arr_1),
    .rd_2 (arr_2)
  );
`ifdef REGFILE_BYPASS_EN
  // forwarding: incoming result beats writeback result beats array; R0 always zero
  always_comb begin
    src_1 = i_rd_add_1 == REG_ZERO ? '0
          : (i_wr_valid && i_write_add == i_rd_add_1) ? i_write_data
          : (wb_valid && wb_add == i_rd_add_1) ? wb_data : arr_1;
    src_2 = i_rd_add_2 == REG_ZERO ? '0
          : (i_wr_valid && i_write_add == i_rd_add_2) ? i_write_data
          : (wb_valid && wb_add == i_rd_add_2) ? wb_data : arr_2;
  end
`else
  // no forwarding: operands come straight from the array (read before write)
  always_comb begin
    src_1 = arr_1;
    src_2 = arr_2;
  end
`endif
  // registered operands, held while no read is requested
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_srcdata_1 <= '0;
      o_srcdata_2 <= '0;
      o_rd_valid  <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        o_srcdata_1 <= src_1;
        o_srcdata_2 <= src_2;
      end
    end
  // committed-write counter, wraps naturally at 8 bits
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_commit_cnt <= '0;
    else if (commit) o_commit_cnt <= o_commit_cnt + 8'd1;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed checks of writeback, commit, R0, counter wrap, reset discard and optional bypass
module tb_regfile_writeback;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] write_add = '0;
  logic [7:0] write_data = '0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_add_1 = '0;
  logic [3:0] rd_add_2 = '0;
  logic [7:0] src_1, src_2, commit_cnt;
  logic       rd_valid;
  int checks = 0;
  int errors = 0;

  regfile_writeback dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wr_valid  (wr_valid),
    .i_write_add (write_add),
    .i_write_data(write_data),
    .i_rd_en     (rd_en),
    .i_rd_add_1  (rd_add_1),
    .i_rd_add_2  (rd_add_2),
    .o_srcdata_1 (src_1),
    .o_srcdata_2 (src_2),
    .o_rd_valid  (rd_valid),
    .o_commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic v, input logic [3:0] a, input logic [7:0] d);
    wr_valid = v;
    write_add = a;
    write_data = d;
  endtask

  task automatic rd(input logic en, input logic [3:0] a1, input logic [3:0] a2);
    rd_en = en;
    rd_add_1 = a1;
    rd_add_2 = a2;
  endtask

  initial begin
    #12;
    check("reset_src1", src_1, 8'h00);
    check("reset_valid", {7'd0, rd_valid}, 8'h00);
    check("reset_cnt", commit_cnt, 8'h00);
    rst_n = 1'b1;
    rd(1, 4'd3, 4'd7);
    step();
    check("rd37_src1", src_1, 8'h00);
    check("rd37_src2", src_2, 8'h00);
    check("rd37_valid", {7'd0, rd_valid}, 8'h01);
    check("rd37_cnt", commit_cnt, 8'h00);
    rd(0, 4'd0, 4'd0);
    step();
    check("idle_valid", {7'd0, rd_valid}, 8'h00);
    // R5=A5: captured at N, committed at N+1
    wr(1, 4'd5, 8'hA5);
    step();
    wr(0, 4'd0, 8'h00);
    rd(1, 4'd5, 4'd5);
    step();
    check("r5_n1", src_1, BYP ? 8'hA5 : 8'h00);
    check("r5_cnt", commit_cnt, 8'h01);
    step();
    check("r5_n2_p1", src_1, 8'hA5);
    check("r5_n2_p2", src_2, 8'hA5);
    // R2=3C with read in the same cycle; port 2 reads untouched R3
    wr(1, 4'd2, 8'h3C);
    rd(1, 4'd2, 4'd3);
    step();
    wr(0, 4'd0, 8'h00);
    check("r2_n0", src_1, BYP ? 8'h3C : 8'h00);
    check("r2_n0_p2", src_2, 8'h00);
    step();
    check("r2_n1", src_1, BYP ? 8'h3C : 8'h00);
    step();
    check("r2_n2", src_1, 8'h3C);
    check("r2_cnt", commit_cnt, 8'h02);
    rd(0, 4'd5, 4'd5);
    step();
    check("hold_src1", src_1, 8'h3C);
    check("hold_valid", {7'd0, rd_valid}, 8'h00);
    // R0 write dropped, not counted, reads zero even with bypass
    wr(1, 4'd0, 8'hFF);
    rd(1, 4'd0, 4'd0);
    step();
    check("r0_same", src_1, 8'h00);
    wr(0, 4'd0, 8'h00);
    step();
    check("r0_wb", src_2, 8'h00);
    step();
    check("r0_arr", src_1, 8'h00);
    check("r0_cnt", commit_cnt, 8'h02);
    // back-to-back writes to R4, last one wins
    rd(0, 4'd0, 4'd0);
    wr(1, 4'd4, 8'h10);
    step();
    wr(1, 4'd4, 8'h20);
    step();
    wr(0, 4'd0, 8'h00);
    step();
    rd(1, 4'd4, 4'd5);
    step();
    check("b2b_r4", src_1, 8'h20);
    check("b2b_r5", src_2, 8'hA5);
    check("b2b_cnt", commit_cnt, 8'h04);
    // counter wrap: 251 more commits reach 255, one more wraps to 0
    rd(0, 4'd0, 4'd0);
    for (int i = 0; i < 251; i++) begin
      wr(1, 4'd1, 8'(i));
      step();
    end
    wr(0, 4'd0, 8'h00);
    step();
    check("cnt_255", commit_cnt, 8'hFF);
    wr(1, 4'd1, 8'h77);
    step();
    wr(0, 4'd0, 8'h00);
    step();
    check("cnt_wrap", commit_cnt, 8'h00);
    rd(1, 4'd1, 4'd2);
    step();
    check("r1_last", src_1, 8'h77);
    check("r2_keep", src_2, 8'h3C);
    // reset between capture and commit discards the write
    rd(0, 4'd0, 4'd0);
    wr(1, 4'd6, 8'h5A);
    step();
    wr(0, 4'd0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_src1", src_1, 8'h00);
    check("arst_valid", {7'd0, rd_valid}, 8'h00);
    #3;
    rst_n = 1'b1;
    step();
    step();
    rd(1, 4'd6, 4'd5);
    step();
    check("rst_r6", src_1, 8'h00);
    check("rst_r5", src_2, 8'h00);
    check("rst_cnt", commit_cnt, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
